// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage behind the 16-bit ALU.
// Captures one ALU result per accepted transaction and drives it onto the
// single register-file write port. A wide (32-bit) result is written as two
// sequential writes: low word first, then high word.
// Also holds the architectural flags register {C,Z,V,N} with per-bit write mask.
// Optional feature: define ALU_WB_FWD_EN to expose the pending write on the
// fwd_* bypass port; otherwise fwd_* are tied to 0.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no write pending, ready for a new result
// LO    | low-word write presented, waiting for rf_gnt
// HI    | high-word write presented, waiting for rf_gnt
module alu_writeback #(
  parameter int N  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_dest,
  input  logic [AW-1:0] in_dest_hi,
  input  logic          in_wide,
  input  logic          in_hi_sel,
  input  logic [N-1:0]  in_y,
  input  logic [N-1:0]  in_yhigh,
  input  logic [N-1:0]  in_out_to_a,
  input  logic          in_co,
  input  logic          in_zero,
  input  logic          in_overflow,
  input  logic          in_negative,
  input  logic [3:0]    in_flag_we,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [N-1:0]  rf_data,
  input  logic          rf_gnt,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          busy,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [N-1:0]  fwd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  lo_q, hi_q;
  logic [AW-1:0] dest_q, dest_hi_q;
  logic          wide_q;
  logic [3:0]    flags_q;
  logic [3:0]    flags_in;
  logic          accept;

  // Flag inputs packed in the same {C,Z,V,N} order as the write mask.
  assign flags_in = {in_co, in_zero, in_overflow, in_negative};
  assign accept   = in_valid & in_ready;

  // State register; reset discards any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result capture at acceptance. in_ready is low whenever the current
  // result still needs its high write, so the holding registers are never
  // overwritten while they are still in use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      hi_q      <= '0;
      dest_q    <= '0;
      dest_hi_q <= '0;
      wide_q    <= 1'b0;
    end else if (accept) begin
      lo_q      <= in_y;
      hi_q      <= in_hi_sel ? in_out_to_a : in_yhigh;
      dest_q    <= in_dest;
      dest_hi_q <= in_dest_hi;
      wide_q    <= in_wide;
    end
  end

  // Flags update at acceptance, bit-masked, independent of the write grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept) begin
      flags_q <= (flags_q & ~in_flag_we) | (flags_in & in_flag_we);
    end
  end

  // Next state, ready and write-port outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_data  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = LO;
        end
      end
      LO: begin
        rf_we    = 1'b1;
        rf_addr  = dest_q;
        rf_data  = lo_q;
        in_ready = ~wide_q & rf_gnt;
        if (rf_gnt) begin
          if (wide_q) begin
            state_d = HI;
          end else if (in_valid) begin
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HI: begin
        rf_we    = 1'b1;
        rf_addr  = dest_hi_q;
        rf_data  = hi_q;
        in_ready = rf_gnt;
        if (rf_gnt) begin
          state_d = in_valid ? LO : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign flag_c = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_n = flags_q[0];

`ifdef ALU_WB_FWD_EN
  // Bypass view of the pending write, valid even while the grant is withheld.
  assign fwd_valid = busy;
  assign fwd_addr  = rf_addr;
  assign fwd_data  = rf_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: directed steps followed by random traffic,
// all checked against a queue-of-pending-writes reference model.
module tb_alu_writeback;

  localparam int N  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_dest;
  logic [AW-1:0] in_dest_hi;
  logic          in_wide;
  logic          in_hi_sel;
  logic [N-1:0]  in_y;
  logic [N-1:0]  in_yhigh;
  logic [N-1:0]  in_out_to_a;
  logic          in_co;
  logic          in_zero;
  logic          in_overflow;
  logic          in_negative;
  logic [3:0]    in_flag_we;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [N-1:0]  rf_data;
  logic          rf_gnt;
  logic          flag_c;
  logic          flag_z;
  logic          flag_v;
  logic          flag_n;
  logic          busy;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [N-1:0]  fwd_data;

  alu_writeback #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_dest_hi(in_dest_hi),
    .in_wide(in_wide), .in_hi_sel(in_hi_sel),
    .in_y(in_y), .in_yhigh(in_yhigh), .in_out_to_a(in_out_to_a),
    .in_co(in_co), .in_zero(in_zero), .in_overflow(in_overflow), .in_negative(in_negative),
    .in_flag_we(in_flag_we),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_gnt(rf_gnt),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .busy(busy),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of register-file writes still owed, plus flags.
  typedef struct {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
  } wr_t;

  wr_t        pend[$];
  logic [3:0] mflags;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs against the model
  // mid-cycle, then advance the model across the rising edge.
  task automatic cyc(input logic v, input logic [AW-1:0] d, input logic [AW-1:0] dh,
                     input logic w, input logic hs, input logic [N-1:0] y,
                     input logic [N-1:0] yh, input logic [N-1:0] ota,
                     input logic [3:0] fl, input logic [3:0] fwe, input logic g);
    logic          e_busy, e_ready, acc;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_data;
    wr_t           e;
    in_valid = v; in_dest = d; in_dest_hi = dh; in_wide = w; in_hi_sel = hs;
    in_y = y; in_yhigh = yh; in_out_to_a = ota;
    {in_co, in_zero, in_overflow, in_negative} = fl;
    in_flag_we = fwe; rf_gnt = g;
    @(negedge clk);
    e_busy  = (pend.size() != 0);
    e_ready = (pend.size() == 0) || (pend.size() == 1 && g);
    e_addr  = e_busy ? pend[0].a : '0;
    e_data  = e_busy ? pend[0].d : '0;
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_busy});
    chk("rf_addr", {29'd0, rf_addr}, {29'd0, e_addr});
    chk("rf_data", {16'd0, rf_data}, {16'd0, e_data});
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("flags", {28'd0, flag_c, flag_z, flag_v, flag_n}, {28'd0, mflags});
`ifdef ALU_WB_FWD_EN
    chk("fwd", {fwd_valid, 12'd0, fwd_addr, fwd_data}, {e_busy, 12'd0, e_addr, e_data});
`else
    chk("fwd", {fwd_valid, 12'd0, fwd_addr, fwd_data}, 32'd0);
`endif
    acc = v && e_ready;
    @(posedge clk);
    if (e_busy && g) pend.pop_front();
    if (acc) begin
      e.a = d; e.d = y;
      pend.push_back(e);
      if (w) begin
        e.a = dh; e.d = hs ? ota : yh;
        pend.push_back(e);
      end
      for (int i = 0; i < 4; i++) if (fwe[i]) mflags[i] = fl[i];
    end
    #1;
  endtask

  task automatic idle(input logic g);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 4'b0000, 4'b0000, g);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_dest = '0; in_dest_hi = '0; in_wide = 0; in_hi_sel = 0;
    in_y = '0; in_yhigh = '0; in_out_to_a = '0;
    in_co = 0; in_zero = 0; in_overflow = 0; in_negative = 0;
    in_flag_we = '0; rf_gnt = 0;
    mflags = 4'b0000;
    #3;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_addr_data", {13'd0, rf_addr, rf_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {28'd0, flag_c, flag_z, flag_v, flag_n}, 32'd0);
    chk("rst_fwd", {fwd_valid, 12'd0, fwd_addr, fwd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Narrow write
    cyc(1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0, 4'b1000, 4'b1111, 1'b1);
    chk("narrow_we", {31'd0, rf_we}, 32'd1);
    chk("narrow_addr", {29'd0, rf_addr}, 32'd3);
    chk("narrow_data", {16'd0, rf_data}, 32'h1234);
    chk("narrow_flag_c", {31'd0, flag_c}, 32'd1);
    idle(1'b1);
    chk("narrow_idle", {31'd0, busy}, 32'd0);

    // Wide write, high word from out_to_a
    cyc(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 16'h0001, 16'h5555, 16'hFFFF, 4'b0000, 4'b0000, 1'b1);
    chk("wide_lo", {13'd0, rf_addr, rf_data}, {13'd0, 3'd2, 16'h0001});
    chk("wide_lo_ready", {31'd0, in_ready}, 32'd0);
    idle(1'b1);
    chk("wide_hi", {13'd0, rf_addr, rf_data}, {13'd0, 3'd1, 16'hFFFF});
    idle(1'b1);
    idle(1'b1);

    // Back-to-back narrow
    for (int i = 0; i < 4; i++)
      cyc(1'b1, AW'(i + 4), 3'd0, 1'b0, 1'b0, 16'hA000 + 16'(i), 16'h0, 16'h0, 4'b0000, 4'b0000, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Grant stall during LO of a wide result, high word from yhigh
    cyc(1'b1, 3'd5, 3'd6, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("stall_lo", {13'd0, rf_addr, rf_data}, {13'd0, 3'd5, 16'hAAAA});
    end
    idle(1'b1);
    chk("stall_hi", {13'd0, rf_addr, rf_data}, {13'd0, 3'd6, 16'hBBBB});
    idle(1'b1);

    // Same destination for both words: high lands last
    cyc(1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 4'b0000, 1'b1);
    idle(1'b1);
    chk("same_dest_hi", {13'd0, rf_addr, rf_data}, {13'd0, 3'd7, 16'h2222});
    idle(1'b1);

    // Flag mask
    cyc(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1111, 4'b1111, 1'b1);
    cyc(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b0000, 4'b0100, 1'b1);
    chk("flag_mask", {28'd0, flag_c, flag_z, flag_v, flag_n}, 32'b1011);
    cyc(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b0000, 4'b0000, 1'b1);
    chk("flag_zero_mask", {28'd0, flag_c, flag_z, flag_v, flag_n}, 32'b1011);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), N'($urandom), N'($urandom), N'($urandom),
          4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset mid-HI
    cyc(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 16'h4321, 16'h8765, 16'h0, 4'b1111, 4'b1111, 1'b1);
    idle(1'b1);
    chk("pre_rst_hi", {13'd0, rf_addr, rf_data}, {13'd0, 3'd2, 16'h8765});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hi_we", {31'd0, rf_we}, 32'd0);
    chk("rst_hi_flags", {28'd0, flag_c, flag_z, flag_v, flag_n}, 32'd0);
    chk("rst_hi_out", {13'd0, rf_addr, rf_data}, 32'd0);
    pend.delete();
    mflags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    cyc(1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 16'h0BAD, 16'h0, 16'h0, 4'b0001, 4'b0001, 1'b1);
    chk("post_rst_write", {13'd0, rf_addr, rf_data}, {13'd0, 3'd6, 16'h0BAD});
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
